exec_monitor: RTL
=================

# exec_monitor

Synthesizable execution monitor for the single-cycle RISC-V core. It watches the retired-instruction PC stream and counts how often the core retires each of `N_WATCH` programmable PC addresses. It also counts run cycles, detects program completion as a self-loop halt, and flags a watchdog timeout. It sits beside `singlecycle`, fed from `o_pc_debug`/`o_insn_vld`, so loop-count and completion checks run in hardware (FPGA bring-up) as well as in simulation.

## Interface
- `N_WATCH`, 4: number of independent PC watch channels (1..16)
- `CNT_W`, 16: width of each per-channel hit counter (saturating)
- `CYC_W`, 32: width of the run-cycle counter
- `MAX_CYC`, 300: watchdog limit in RUN cycles (≥2, < 2^CYC_W)
- `HALT_CYC`, 4: consecutive valid retirements at an unchanged PC that declare a halt (≥2)

Ports:
- `i_clk`  in  1  system clock, rising edge
- `i_reset`  in  1  asynchronous, active-high reset
- `i_pc`  in  32  PC of retiring instruction (`o_pc_debug`)
- `i_insn_vld`  in  1  retirement valid qualifier
- `i_start`  in  1  pulse: begin a measurement run (honoured in IDLE only)
- `i_clear`  in  1  pulse: abort/clear, return to IDLE (any state)
- `i_watch_addr`  in  N_WATCH×32  watch addresses, unpacked array
- `i_watch_en`  in  N_WATCH  per-channel enable
- `o_hit_cnt`  out  N_WATCH×CNT_W  per-channel hit counts
- `o_cycle_cnt`  out  CYC_W  RUN cycles elapsed
- `o_state`  out  2  IDLE=0, RUN=1, HALTED=2, TIMEOUT=3
- `o_done`  out  1  high in HALTED
- `o_timeout`  out  1  high in TIMEOUT
- `o_halt_pc`  out  32  PC at which the halt was detected

## Operation
- FSM states: IDLE, RUN, HALTED, TIMEOUT.
  - IDLE→RUN on `i_start`. Entry clears all hit counters, the cycle counter, the stable counter and `o_halt_pc`.
  - RUN→HALTED when the halt condition is met.
  - RUN→TIMEOUT when the watchdog expires.
  - HALTED and TIMEOUT are sticky. They leave only via `i_clear` to IDLE; `i_start` is ignored there.
  - `i_clear` from any state goes to IDLE and zeroes all counters and `o_halt_pc`. It has priority over `i_start` in the same cycle.
- Hit counting happens only in RUN. Channel k increments when `i_insn_vld & i_watch_en[k] & (i_pc == i_watch_addr[k])`.
  - The counter saturates at 2^CNT_W−1.
  - Several channels may hit in the same cycle, including duplicate addresses; each counts independently.
- Cycle counter: increments every RUN cycle, whether or not an instruction is valid. It freezes outside RUN.
- Watchdog: in RUN, if `o_cycle_cnt == MAX_CYC−1`, the next state is TIMEOUT and the counter becomes MAX_CYC.
- Halt detection: a stable counter and last-PC register operate in RUN only.
  - On a valid retirement with `i_pc == last_pc`, the stable counter increments (saturating at HALT_CYC).
  - On a valid retirement with a different PC, the stable counter resets to 1 and last_pc is loaded.
  - Invalid cycles hold both the counter and last_pc.
  - The first valid retirement after start loads last_pc with count 1.
  - When the increment reaches HALT_CYC, the next state is HALTED and `o_halt_pc` = `i_pc`.
- Halt and watchdog in the same cycle: HALTED wins.
- Hits in the transition cycle are still counted.
- Changing `i_watch_addr`/`i_watch_en` mid-run takes effect on the next compare. There is no shadowing.

## Timing
- All outputs are registered. A qualifying retirement on cycle t is visible on the outputs at t+1.
- Halt latency: `o_done` rises one cycle after the HALT_CYC-th matching retirement.
- Timeout latency: `o_timeout` rises on the clock that loads `o_cycle_cnt` = MAX_CYC.
- Reset values (asynchronous, immediate): state IDLE, `o_hit_cnt` all 0, `o_cycle_cnt` 0, `o_done` 0, `o_timeout` 0, `o_halt_pc` 0.
- Reset mid-run aborts with no partial state retained. After release, the block waits in IDLE for `i_start`.
- The block has no combinational path from inputs to outputs.

## Structure
- Package `exec_mon_pkg`: state enum `exec_mon_state_e` (2-bit, encodings above) and the default parameter constants.
- Sub-module `exec_mon_chan`, instantiated `N_WATCH` times by generate. It holds the comparator plus a saturating CNT_W counter, with clear, enable and run-qualify inputs.
- The top holds the FSM, cycle counter, stable counter, last_pc and halt_pc registers.

## Test plan
- Sum 1..50 program, channel 0 = 0x08, start after reset → `o_hit_cnt[0]`=50, `o_done`=1, `o_halt_pc` = address of final `j .`, `o_timeout`=0.
- Hold `i_pc`=0x10 valid every cycle with HALT_CYC=4 → `o_done` rises exactly 4 cycles after the first valid retirement, `o_halt_pc`=0x10. Inserting an invalid cycle mid-sequence delays it by 1.
- Free-running PC increment (no self-loop), MAX_CYC=300 → `o_timeout`=1 and `o_cycle_cnt`=300 at cycle 300, state 3. Subsequent `i_start` is ignored; `i_clear` returns to IDLE with all counters 0.
- CNT_W=4, watched PC retired 20 times → `o_hit_cnt` saturates at 15. Two channels on the same address both count; a disabled channel stays 0.
- Same-cycle halt and watchdog (align the HALT_CYC-th repeat with cycle MAX_CYC−1) → state HALTED, `o_timeout`=0.
- Assert `i_reset` for one cycle mid-RUN at count 17 → outputs zero asynchronously, state IDLE. `i_start` and `i_clear` together → IDLE.

Source files
------------

// File: rtl/exec_mon_pkg.sv
// Shared types and default parameters for the retired-PC execution monitor.
package exec_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_HALTED  = 2'd2,
        ST_TIMEOUT = 2'd3
    } exec_mon_state_e;

    localparam int unsigned DEF_N_WATCH  = 32'd4;
    localparam int unsigned DEF_CNT_W    = 32'd16;
    localparam int unsigned DEF_CYC_W    = 32'd32;
    localparam int unsigned DEF_MAX_CYC  = 32'd300;
    localparam int unsigned DEF_HALT_CYC = 32'd4;

endpackage

// File: rtl/exec_monitor_if.sv
// Bundles the retirement stream, run control, watch configuration and monitor results.
interface exec_monitor_if
    import exec_mon_pkg::*;
#(
    parameter int unsigned N_WATCH = DEF_N_WATCH,
    parameter int unsigned CNT_W   = DEF_CNT_W,
    parameter int unsigned CYC_W   = DEF_CYC_W
);
    logic [31:0]        i_pc;
    logic               i_insn_vld;
    logic               i_start;
    logic               i_clear;
    logic [31:0]        i_watch_addr [N_WATCH];
    logic [N_WATCH-1:0] i_watch_en;
    logic [CNT_W-1:0]   o_hit_cnt [N_WATCH];
    logic [CYC_W-1:0]   o_cycle_cnt;
    logic [1:0]         o_state;
    logic               o_done;
    logic               o_timeout;
    logic [31:0]        o_halt_pc;

    modport master (
        output i_pc, i_insn_vld, i_start, i_clear, i_watch_addr, i_watch_en,
        input  o_hit_cnt, o_cycle_cnt, o_state, o_done, o_timeout, o_halt_pc
    );

    modport slave (
        input  i_pc, i_insn_vld, i_start, i_clear, i_watch_addr, i_watch_en,
        output o_hit_cnt, o_cycle_cnt, o_state, o_done, o_timeout, o_halt_pc
    );
endinterface

// File: rtl/exec_mon_chan.sv
// One PC watch channel: address comparator feeding a saturating hit counter.
module exec_mon_chan #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             run_i,
    input  logic             vld_i,
    input  logic             en_i,
    input  logic [31:0]      pc_i,
    input  logic [31:0]      addr_i,
    output logic [CNT_W-1:0] cnt_o
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             hit_s;

    // Next count: clear wins, otherwise count qualified hits until full scale.
    always_comb begin
        hit_s = run_i & vld_i & en_i & (pc_i == addr_i);
        if (clr_i) begin
            cnt_d = '0;
        end else if (hit_s && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Hit counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/exec_monitor.sv
// Execution monitor: run FSM, cycle watchdog, self-loop halt detector and watch channels.
module exec_monitor
    import exec_mon_pkg::*;
#(
    parameter int unsigned N_WATCH  = DEF_N_WATCH,
    parameter int unsigned CNT_W    = DEF_CNT_W,
    parameter int unsigned CYC_W    = DEF_CYC_W,
    parameter int unsigned MAX_CYC  = DEF_MAX_CYC,
    parameter int unsigned HALT_CYC = DEF_HALT_CYC
) (
    input logic           i_clk,
    input logic           i_reset,
    exec_monitor_if.slave bus
);
    localparam int unsigned      STB_W    = $clog2(HALT_CYC + 1);
    localparam logic [STB_W-1:0] STB_HALT = STB_W'(HALT_CYC);
    localparam logic [STB_W-1:0] STB_ONE  = STB_W'(1);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(MAX_CYC - 1);
    localparam logic [CYC_W-1:0] CYC_ONE  = CYC_W'(1);

    exec_mon_state_e  state_q, state_d;
    logic [CYC_W-1:0] cycle_q, cycle_d;
    logic [STB_W-1:0] stable_q, stable_d;
    logic [31:0]      last_pc_q, last_pc_d;
    logic [31:0]      halt_pc_q, halt_pc_d;
    logic             done_q, timeout_q;
    logic             halt_hit_s;
    logic             chan_clr_s;
    logic             run_s;
    logic [CNT_W-1:0] hit_cnt_s [N_WATCH];

    // Next-state logic for the FSM and the run bookkeeping counters.
    always_comb begin
        state_d    = state_q;
        cycle_d    = cycle_q;
        stable_d   = stable_q;
        last_pc_d  = last_pc_q;
        halt_pc_d  = halt_pc_q;
        halt_hit_s = 1'b0;
        if (bus.i_clear) begin
            state_d   = ST_IDLE;
            cycle_d   = '0;
            stable_d  = '0;
            last_pc_d = '0;
            halt_pc_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        state_d   = ST_RUN;
                        cycle_d   = '0;
                        stable_d  = '0;
                        last_pc_d = '0;
                        halt_pc_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    cycle_d = cycle_q + CYC_ONE;
                    // stable_q == 0 marks "no retirement seen yet", so PC 0 cannot fake a repeat.
                    if (bus.i_insn_vld) begin
                        if ((stable_q != '0) && (bus.i_pc == last_pc_q)) begin
                            if ((stable_q + STB_ONE) >= STB_HALT) begin
                                stable_d   = STB_HALT;
                                halt_hit_s = 1'b1;
                            end else begin
                                stable_d = stable_q + STB_ONE;
                            end
                        end else begin
                            stable_d  = STB_ONE;
                            last_pc_d = bus.i_pc;
                        end
                    end else begin
                        stable_d = stable_q;
                    end
                    if (halt_hit_s) begin
                        state_d   = ST_HALTED;
                        halt_pc_d = bus.i_pc;
                    end else if (cycle_q == CYC_LAST) begin
                        state_d = ST_TIMEOUT;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_HALTED:  state_d = ST_HALTED;
                ST_TIMEOUT: state_d = ST_TIMEOUT;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    // Register bank; done/timeout are registered decodes of the next state.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= ST_IDLE;
            cycle_q   <= '0;
            stable_q  <= '0;
            last_pc_q <= '0;
            halt_pc_q <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cycle_q   <= cycle_d;
            stable_q  <= stable_d;
            last_pc_q <= last_pc_d;
            halt_pc_q <= halt_pc_d;
            done_q    <= (state_d == ST_HALTED);
            timeout_q <= (state_d == ST_TIMEOUT);
        end
    end

    assign chan_clr_s = bus.i_clear | ((state_q == ST_IDLE) & bus.i_start);
    assign run_s      = (state_q == ST_RUN);

    for (genvar k = 0; k < N_WATCH; k++) begin : g_chan
        exec_mon_chan #(.CNT_W(CNT_W)) u_chan (
            .clk_i  (i_clk),
            .rst_i  (i_reset),
            .clr_i  (chan_clr_s),
            .run_i  (run_s),
            .vld_i  (bus.i_insn_vld),
            .en_i   (bus.i_watch_en[k]),
            .pc_i   (bus.i_pc),
            .addr_i (bus.i_watch_addr[k]),
            .cnt_o  (hit_cnt_s[k])
        );
    end

    assign bus.o_hit_cnt   = hit_cnt_s;
    assign bus.o_cycle_cnt = cycle_q;
    assign bus.o_state     = state_q;
    assign bus.o_done      = done_q;
    assign bus.o_timeout   = timeout_q;
    assign bus.o_halt_pc   = halt_pc_q;
endmodule
